pipeline_fetch_ctrl: RTL

//  Front end of the 5-stage core, upstream of S0 decode. Owns the 8-bit PC and

---
 rtl/kaiser_core_pkg.sv | 27 ++
 rtl/pipeline_fetch_ctrl_stall_ctr.sv | 52 +++++
 rtl/pipeline_fetch_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/kaiser_core_pkg.sv
// Shared definitions for the front end of the 5-stage core.
// Holds the fetch FSM state type, the bubble/halt instruction encodings,
// the opcode field position and the datapath widths. The decode stage
// imports the same package, so the opcode slice is defined only once.
package kaiser_core_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSN_W  = 16;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 13;

    localparam logic [INSN_W-1:0] NOP_INSN = 16'h0000;
    localparam logic [2:0]        HALT_OPC = 3'b111;

    typedef enum logic [1:0] {
        FS_INIT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_STALL = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

    // Opcode field of an instruction word.
    function automatic logic [2:0] insn_opcode(input logic [INSN_W-1:0] insn);
        return insn[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/pipeline_fetch_ctrl_stall_ctr.sv
// fetch_stall_ctr: counts the remaining load-use bubble cycles.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   clear_i abort a pending stall (taken branch); highest priority
//   load_i  start a stall: counter reloads with LOAD_CYC-1
//   dec_i   count one stall cycle down (ignored at zero)
//   last_o  high when the current stall cycle is the final one
module fetch_stall_ctr #(
    parameter int unsigned LOAD_CYC = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    // The first bubble is issued in the hazard cycle itself, so only
    // LOAD_CYC-1 further cycles are counted here.
    localparam logic [1:0] RELOAD = 2'(LOAD_CYC - 1);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Counter next-state: clear beats load beats decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (load_i) begin
            cnt_d = RELOAD;
        end else if (dec_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == 2'd1);

endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// pipeline_fetch_ctrl: front end of the 5-stage core, upstream of S0 decode.
// Owns the PC, drives instruction-memory fetch, registers IR/PC into S0,
// and produces the S1 capture enable and the per-stage flush vector.
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-low reset
//   imem_addr    fetch address (the PC register)
//   imem_rdata   instruction at imem_addr, same cycle
//   IR_out       fetched instruction to S0
//   PC_out       PC of IR_out to S0
//   update_1out  S1 capture enable
//   rst_p        stage flushes [4:1]
//   loads_1in    S1 holds a load
//   ld_hazard    S0 instruction sources the S1 load's destination
//   br_taken     S2 resolved a taken branch
//   br_target    redirect PC, valid with br_taken
//   halted       core is in HALT
module pipeline_fetch_ctrl
    import kaiser_core_pkg::*;
#(
    parameter logic [INSN_W-1:0] NOP_INSN       = kaiser_core_pkg::NOP_INSN,
    parameter logic [2:0]        HALT_OPC       = kaiser_core_pkg::HALT_OPC,
    parameter int unsigned       LOAD_STALL_CYC = 2,
    parameter logic [PC_W-1:0]   RESET_PC       = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [INSN_W-1:0] IR_out,
    output logic [PC_W-1:0]   PC_out,
    output logic              update_1out,
    output logic [4:1]        rst_p,
    input  logic              loads_1in,
    input  logic              ld_hazard,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]   pcir_q, pcir_d;

    logic stall_clear_s;
    logic stall_load_s;
    logic stall_dec_s;
    logic stall_last_s;

    fetch_stall_ctr #(
        .LOAD_CYC (LOAD_STALL_CYC)
    ) u_stall_ctr (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clear_i (stall_clear_s),
        .load_i  (stall_load_s),
        .dec_i   (stall_dec_s),
        .last_o  (stall_last_s)
    );

    // Next-state and decoded outputs. A taken branch outranks everything
    // except INIT: it kills any pending stall (the load was wrong-path)
    // and is the only way out of HALT short of reset.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        pcir_d        = pcir_q;
        update_1out   = 1'b0;
        rst_p         = 4'b0000;
        stall_clear_s = 1'b0;
        stall_load_s  = 1'b0;
        stall_dec_s   = 1'b0;

        if ((state_q != FS_INIT) && br_taken) begin
            pc_d          = br_target;
            ir_d          = NOP_INSN;
            pcir_d        = br_target;
            rst_p[2:1]    = 2'b11;
            update_1out   = 1'b1;
            stall_clear_s = 1'b1;
            state_d       = FS_RUN;
        end else begin
            case (state_q)
                FS_INIT: begin
                    // Pipeline flush while coming out of reset; PC not advanced.
                    rst_p   = 4'b1111;
                    state_d = FS_RUN;
                end
                FS_RUN: begin
                    if (loads_1in && ld_hazard) begin
                        // Hold fetch, bubble into S2.
                        rst_p[2]     = 1'b1;
                        stall_load_s = 1'b1;
                        state_d      = (LOAD_STALL_CYC > 1) ? FS_STALL : FS_RUN;
                    end else if (insn_opcode(imem_rdata) == HALT_OPC) begin
                        // Let HALT itself drain down the pipe, freeze the PC.
                        ir_d        = imem_rdata;
                        pcir_d      = pc_q;
                        update_1out = 1'b1;
                        state_d     = FS_HALT;
                    end else begin
                        ir_d        = imem_rdata;
                        pcir_d      = pc_q;
                        pc_d        = pc_q + 8'd1;
                        update_1out = 1'b1;
                    end
                end
                FS_STALL: begin
                    rst_p[2]    = 1'b1;
                    stall_dec_s = 1'b1;
                    if (stall_last_s) begin
                        state_d = FS_RUN;
                    end else begin
                        state_d = FS_STALL;
                    end
                end
                FS_HALT: begin
                    ir_d        = NOP_INSN;
                    update_1out = 1'b1;
                end
                default: begin
                    state_d = FS_INIT;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FS_INIT;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSN;
            pcir_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcir_q  <= pcir_d;
        end
    end

    assign imem_addr = pc_q;
    assign IR_out    = ir_q;
    assign PC_out    = pcir_q;
    assign halted    = (state_q == FS_HALT);

endmodule
